// File: rtl/feynman_checker.sv
// feynman_checker: runs NUM_VEC vectors through a Feynman (CNOT) gate check.
// A vector is accepted on in_valid && in_ready. Its check completes one cycle later.
// Optional first-failure capture is enabled with macro FEYNMAN_FIRST_FAIL_EN.
module feynman_checker #(
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic [1:0]       in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
`ifdef FEYNMAN_FIRST_FAIL_EN
    output logic             ff_valid,
    output logic [CNT_W-1:0] ff_index,
    output logic [3:0]       ff_data,
`endif
    output logic [3:0]       coverage
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             pass_q, pass_d;
    // Pipeline stage holding the accepted vector until its check completes
    logic             pv_q, pv_d;
    logic             pa_q, pa_d;
    logic             pb_q, pb_d;
    logic [1:0]       pout_q, pout_d;
    logic [1:0]       exp_out;
    logic             mismatch;
    logic             accept;
`ifdef FEYNMAN_FIRST_FAIL_EN
    logic [CNT_W-1:0] pidx_q, pidx_d;
    logic             ffv_q, ffv_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;
    logic [3:0]       ffd_q, ffd_d;
`endif

    assign in_ready = (state_q == RUN) && (vec_q < LAST);
    assign accept   = in_valid && in_ready;
    assign exp_out  = {pa_q ^ pb_q, pa_q};
    // Case inequality so an X/Z response reads as a mismatch in simulation
    assign mismatch = (pout_q !== exp_out);

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign vec_count = vec_q;
    assign err_count = err_q;
    assign coverage  = cov_q;
`ifdef FEYNMAN_FIRST_FAIL_EN
    assign ff_valid  = ffv_q;
    assign ff_index  = ffi_q;
    assign ff_data   = ffd_q;
`endif

    // Next-state, acceptance and check logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        cov_d   = cov_q;
        pass_d  = pass_q;
        pv_d    = accept;
        pa_d    = pa_q;
        pb_d    = pb_q;
        pout_d  = pout_q;
`ifdef FEYNMAN_FIRST_FAIL_EN
        pidx_d  = pidx_q;
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;
        ffd_d   = ffd_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    cov_d   = '0;
                    pass_d  = 1'b0;
                    pv_d    = 1'b0;
`ifdef FEYNMAN_FIRST_FAIL_EN
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                    ffd_d   = '0;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    pa_d   = in_a;
                    pb_d   = in_b;
                    pout_d = in_out;
                    vec_d  = (vec_q == '1) ? vec_q : vec_q + 1'b1;
`ifdef FEYNMAN_FIRST_FAIL_EN
                    pidx_d = vec_q;
`endif
                end
                if (pv_q) begin
                    cov_d[{pa_q, pb_q}] = 1'b1;
                    if (mismatch) begin
                        err_d = (err_q == '1) ? err_q : err_q + 1'b1;
`ifdef FEYNMAN_FIRST_FAIL_EN
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffi_d = pidx_q;
                            ffd_d = {pa_q, pb_q, pout_q};
                        end
`endif
                    end
                    // No acceptance is possible once vec_q reaches LAST, so this is the final check
                    if (vec_q == LAST) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0) && (cov_d == 4'b1111);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
            pass_q  <= 1'b0;
            pv_q    <= 1'b0;
            pa_q    <= 1'b0;
            pb_q    <= 1'b0;
            pout_q  <= '0;
`ifdef FEYNMAN_FIRST_FAIL_EN
            pidx_q  <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            ffd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            pass_q  <= pass_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pout_q  <= pout_d;
`ifdef FEYNMAN_FIRST_FAIL_EN
            pidx_q  <= pidx_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
            ffd_q   <= ffd_d;
`endif
        end
    end

endmodule
